// File: rtl/cache_l2_assoc_if.sv
// L1-side, memory-side and prefetch-side signals of the L2 cache; the cache takes the slave view.
// Latency/backpressure are properties of cache_l2_assoc: requests are held until their resp pulse.
interface cache_l2_assoc_if #(
    parameter int BLOCK = 128
);
    logic             mem_read;
    logic             mem_write;
    logic [15:0]      mem_address;
    logic [BLOCK-1:0] mem_wdata;
    logic             mem_resp;
    logic [BLOCK-1:0] mem_rdata;
    logic             pmem_read;
    logic             pmem_write;
    logic [15:0]      pmem_address;
    logic [BLOCK-1:0] pmem_wdata;
    logic             pmem_resp;
    logic [BLOCK-1:0] pmem_rdata;
    logic             prefetch_valid;
    logic [15:0]      prefetch_address;
    logic [BLOCK-1:0] prefetch_wdata;
    logic             prefetch_ack;
    logic             dont_prefetch;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata,
        input  prefetch_valid, prefetch_address, prefetch_wdata,
        output prefetch_ack, dont_prefetch
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata,
        output prefetch_valid, prefetch_address, prefetch_wdata,
        input  prefetch_ack, dont_prefetch
    );
endinterface

// File: rtl/cache_l2_assoc.sv
// N-way write-back/write-allocate L2; hits respond in the request cycle, misses one cycle after the last pmem_resp.
// Requests and pmem transfers are held until their resp; prefetch offers are only taken in an idle cycle.
module cache_l2_assoc #(
    parameter int WAYS     = 4,
    parameter int SETS     = 8,
    parameter int LOG_SETS = 3,
    parameter int BLOCK    = 128
) (
    input  logic            clk,
    input  logic            reset,
    cache_l2_assoc_if.slave bus
);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW = 12 - LOG_SETS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
    state_t state, state_nx;

    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [TW-1:0]    tag_q   [SETS][WAYS];
    logic [BLOCK-1:0] data_q  [SETS][WAYS];
    logic [WW-1:0]    rr_q    [SETS];

    logic [LOG_SETS-1:0] idx, pidx;
    logic [TW-1:0]       tag, ptag;
    logic                hit, phit, req;
    logic [WW-1:0]       hit_way, vic, pvic;

    assign idx  = bus.mem_address[3+LOG_SETS:4];
    assign tag  = bus.mem_address[15:4+LOG_SETS];
    assign pidx = bus.prefetch_address[3+LOG_SETS:4];
    assign ptag = bus.prefetch_address[15:4+LOG_SETS];
    assign req  = bus.mem_read | bus.mem_write;

    logic unused_offsets;
    assign unused_offsets = ^{bus.mem_address[3:0], bus.prefetch_address[3:0]};

    // Descending scan so the lowest-index invalid way overrides the round-robin pick.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        phit    = 1'b0;
        vic     = rr_q[idx];
        pvic    = rr_q[pidx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w])  vic  = WW'(w);
            if (!valid_q[pidx][w]) pvic = WW'(w);
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (valid_q[pidx][w] && tag_q[pidx][w] == ptag) phit = 1'b1;
        end
    end

    logic                upd_en, upd_dirty, upd_adv, clr_dirty;
    logic [LOG_SETS-1:0] upd_set;
    logic [WW-1:0]       upd_way;
    logic [TW-1:0]       upd_tag;
    logic [BLOCK-1:0]    upd_data;

    always_comb begin
        state_nx          = state;
        bus.mem_resp      = 1'b0;
        bus.mem_rdata     = '0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_address  = '0;
        bus.pmem_wdata    = '0;
        bus.prefetch_ack  = 1'b0;
        bus.dont_prefetch = 1'b0;
        upd_en    = 1'b0;
        upd_dirty = 1'b0;
        upd_adv   = 1'b0;
        clr_dirty = 1'b0;
        upd_set   = idx;
        upd_way   = vic;
        upd_tag   = tag;
        upd_data  = bus.mem_wdata;
        if (!reset) begin
            bus.dont_prefetch = (state != IDLE) | req;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            bus.mem_resp = 1'b1;
                            if (bus.mem_read) begin
                                bus.mem_rdata = data_q[idx][hit_way];
                            end else begin
                                upd_en    = 1'b1;
                                upd_way   = hit_way;
                                upd_dirty = 1'b1;
                            end
                        end else if (valid_q[idx][vic] && dirty_q[idx][vic]) begin
                            state_nx = WRITEBACK;
                        end else if (bus.mem_read) begin
                            state_nx = FETCH;
                        end else begin
                            // Full-block write: allocate directly; the held request hits next cycle.
                            upd_en    = 1'b1;
                            upd_dirty = 1'b1;
                            upd_adv   = 1'b1;
                        end
                    end else if (bus.prefetch_valid) begin
                        bus.prefetch_ack = 1'b1;
                        if (!phit && !(valid_q[pidx][pvic] && dirty_q[pidx][pvic])) begin
                            upd_en   = 1'b1;
                            upd_set  = pidx;
                            upd_way  = pvic;
                            upd_tag  = ptag;
                            upd_data = bus.prefetch_wdata;
                            upd_adv  = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write   = 1'b1;
                    bus.pmem_address = {tag_q[idx][vic], idx, 4'h0};
                    bus.pmem_wdata   = data_q[idx][vic];
                    if (bus.pmem_resp) begin
                        clr_dirty = 1'b1;
                        state_nx  = bus.mem_read ? FETCH : IDLE;
                    end
                end
                FETCH: begin
                    bus.pmem_read    = 1'b1;
                    bus.pmem_address = {bus.mem_address[15:4], 4'h0};
                    if (bus.pmem_resp) begin
                        upd_en   = 1'b1;
                        upd_data = bus.pmem_rdata;
                        upd_adv  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state <= state_nx;
            if (clr_dirty) dirty_q[idx][vic] <= 1'b0;
            if (upd_en) begin
                valid_q[upd_set][upd_way] <= 1'b1;
                dirty_q[upd_set][upd_way] <= upd_dirty;
                tag_q[upd_set][upd_way]   <= upd_tag;
                data_q[upd_set][upd_way]  <= upd_data;
            end
            if (upd_adv)
                rr_q[upd_set] <= (rr_q[upd_set] == WW'(WAYS - 1)) ? '0 : rr_q[upd_set] + 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_l2_assoc.sv
// Bench for cache_l2_assoc (2 ways, 8 sets): directed vectors, corner sequences, random traffic vs. a reference model.
module tb_cache_l2_assoc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_l2_assoc_if #(.BLOCK(128)) bus ();
    cache_l2_assoc #(.WAYS(2), .SETS(8), .LOG_SETS(3), .BLOCK(128)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } pm_t;
    pm_t pm_log[$];
    logic [127:0] store  [logic [15:0]];   // physical memory behind the cache
    logic [127:0] shadow [logic [15:0]];   // what the L1 should observe
    int pm_lat = 3;
    int pm_cnt = 0;

    function automatic logic [127:0] init_data(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction
    function automatic logic [15:0] blk(input logic [15:0] a);
        return {a[15:4], 4'h0};
    endfunction
    function automatic logic [127:0] mem_get(input logic [15:0] a);
        return store.exists(blk(a)) ? store[blk(a)] : init_data(blk(a));
    endfunction
    function automatic logic [127:0] truth(input logic [15:0] a);
        return shadow.exists(blk(a)) ? shadow[blk(a)] : init_data(blk(a));
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: answers a held pmem request after pm_lat waiting cycles.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read || bus.pmem_write) begin
                if (pm_cnt >= pm_lat) begin
                    pm_cnt = 0;
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_write) begin
                        store[bus.pmem_address] = bus.pmem_wdata;
                        pm_log.push_back('{1'b1, bus.pmem_address, bus.pmem_wdata});
                    end else begin
                        bus.pmem_rdata = mem_get(bus.pmem_address);
                        pm_log.push_back('{1'b0, bus.pmem_address, 128'h0});
                    end
                end else pm_cnt++;
            end else pm_cnt = 0;
        end
    end

    // Reference model: per-set way contents and round-robin pointer.
    bit         m_v [8][2];
    bit         m_d [8][2];
    logic [8:0] m_t [8][2];
    int         m_rr[8];

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) begin m_v[s][w] = 0; m_d[s][w] = 0; m_t[s][w] = '0; end
        end
    endfunction

    function automatic int pick_victim(input int s);
        int v;
        v = m_rr[s];
        if (!m_v[s][1]) v = 1;
        if (!m_v[s][0]) v = 0;
        return v;
    endfunction

    function automatic void model_req(input bit wr, input logic [15:0] a, input int L, output int lat,
                                      output bit wb, output logic [15:0] wb_addr, output bit fetch);
        int s; logic [8:0] t; int v;
        s = int'(a[6:4]); t = a[15:7]; v = -1;
        wb = 0; fetch = 0; wb_addr = '0; lat = 0;
        for (int w = 0; w < 2; w++) if (m_v[s][w] && m_t[s][w] == t) v = w;
        if (v >= 0) begin
            if (wr) m_d[s][v] = 1;
            return;
        end
        v = pick_victim(s);
        wb = m_v[s][v] && m_d[s][v];
        wb_addr = {m_t[s][v], 3'(s), 4'h0};
        fetch = !wr;
        m_v[s][v] = 1; m_d[s][v] = wr; m_t[s][v] = t;
        m_rr[s] = (m_rr[s] + 1) % 2;
        if (wr) lat = wb ? L + 3 : 1;
        else    lat = wb ? 2 * L + 3 : L + 2;
    endfunction

    function automatic bit model_prefetch(input logic [15:0] a);
        int s; logic [8:0] t; int v;
        s = int'(a[6:4]); t = a[15:7];
        for (int w = 0; w < 2; w++) if (m_v[s][w] && m_t[s][w] == t) return 0;
        v = pick_victim(s);
        if (m_v[s][v] && m_d[s][v]) return 0;
        m_v[s][v] = 1; m_d[s][v] = 0; m_t[s][v] = t;
        m_rr[s] = (m_rr[s] + 1) % 2;
        return 1;
    endfunction

    task automatic check_req(input string nm, input bit wr, input logic [15:0] a, input logic [127:0] d,
                             input int L, input int exp_lat, input logic [127:0] exp_rd, input bit exp_wb,
                             input logic [15:0] wb_addr, input logic [127:0] wb_data, input bit exp_fetch);
        int lat; logic [127:0] rd; int k;
        pm_lat = L;
        pm_log.delete();
        @(posedge clk); #1;
        bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a; bus.mem_wdata = d;
        lat = -1; rd = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.mem_resp) begin lat = c; rd = bus.mem_rdata; break; end
        end
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
        if (!wr) chk({nm, " rdata"}, rd, exp_rd);
        chk({nm, " pmem count"}, 128'(pm_log.size()), 128'(int'(exp_wb) + int'(exp_fetch)));
        if (pm_log.size() == int'(exp_wb) + int'(exp_fetch)) begin
            k = 0;
            if (exp_wb) begin
                chk({nm, " wb kind"}, 128'(pm_log[0].wr), 128'(1));
                chk({nm, " wb addr"}, 128'(pm_log[0].addr), 128'(wb_addr));
                chk({nm, " wb data"}, pm_log[0].data, wb_data);
                k = 1;
            end
            if (exp_fetch) begin
                chk({nm, " fetch kind"}, 128'(pm_log[k].wr), 128'(0));
                chk({nm, " fetch addr"}, 128'(pm_log[k].addr), 128'(blk(a)));
            end
        end
    endtask

    task automatic model_check(input string nm, input bit wr, input logic [15:0] a, input logic [127:0] d, input int L);
        int lat; bit wb, fe; logic [15:0] wa; logic [127:0] wd, rd;
        model_req(wr, a, L, lat, wb, wa, fe);
        wd = truth(wa);
        rd = wr ? 128'h0 : truth(a);
        if (wr) shadow[blk(a)] = d;
        check_req(nm, wr, a, d, L, lat, rd, wb, wa, wd, fe);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.prefetch_valid = 1'b0;
        @(negedge clk);
        chk("reset ctrl", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.prefetch_ack, bus.dont_prefetch, bus.pmem_address}), 128'h0);
        chk("reset data", bus.mem_rdata | bus.pmem_wdata, 128'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle ctrl", 128'({bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.prefetch_ack, bus.dont_prefetch, bus.pmem_address}), 128'h0);
        model_reset();
        shadow = store;
        pm_log.delete();
    endtask

    typedef struct {
        bit wr; logic [15:0] addr; logic [127:0] wdata; int lat_mem; int exp_lat; logic [127:0] exp_rd;
        bit exp_wb; logic [15:0] wb_addr; logic [127:0] wb_data; bit exp_fetch;
    } vec_t;
    vec_t vecs[10];

    logic [15:0]  a;
    logic [127:0] d;
    bit           got, installed;
    int           op, L;

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
        bus.prefetch_valid = 1'b0; bus.prefetch_address = '0; bus.prefetch_wdata = '0;
        store[16'h1230] = {16{8'hA5}};

        vecs[0] = '{1'b0, 16'h1230, 128'h0, 3, 5, {16{8'hA5}}, 1'b0, 16'h0, 128'h0, 1'b1};
        vecs[1] = '{1'b0, 16'h1230, 128'h0, 3, 0, {16{8'hA5}}, 1'b0, 16'h0, 128'h0, 1'b0};
        vecs[2] = '{1'b1, 16'h0010, {16{8'h11}}, 3, 1, 128'h0, 1'b0, 16'h0, 128'h0, 1'b0};
        vecs[3] = '{1'b1, 16'h0090, {16{8'h22}}, 3, 1, 128'h0, 1'b0, 16'h0, 128'h0, 1'b0};
        vecs[4] = '{1'b1, 16'h0110, {16{8'h33}}, 3, 6, 128'h0, 1'b1, 16'h0010, {16{8'h11}}, 1'b0};
        vecs[5] = '{1'b0, 16'h0190, 128'h0, 3, 9, init_data(16'h0190), 1'b1, 16'h0090, {16{8'h22}}, 1'b1};
        vecs[6] = '{1'b0, 16'h0090, 128'h0, 3, 9, {16{8'h22}}, 1'b1, 16'h0110, {16{8'h33}}, 1'b1};
        vecs[7] = '{1'b1, 16'h0090, {16{8'h44}}, 3, 0, 128'h0, 1'b0, 16'h0, 128'h0, 1'b0};
        vecs[8] = '{1'b0, 16'h0198, 128'h0, 3, 0, init_data(16'h0190), 1'b0, 16'h0, 128'h0, 1'b0};
        vecs[9] = '{1'b0, 16'h0210, 128'h0, 1, 3, init_data(16'h0210), 1'b0, 16'h0, 128'h0, 1'b1};

        do_reset();
        for (int i = 0; i < 10; i++)
            check_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat_mem,
                      vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].exp_wb, vecs[i].wb_addr, vecs[i].wb_data, vecs[i].exp_fetch);

        // Idle prefetch, then a 0-cycle hit on the prefetched data.
        do_reset();
        @(posedge clk); #1;
        bus.prefetch_valid = 1'b1; bus.prefetch_address = 16'h2040; bus.prefetch_wdata = {16{8'hC3}};
        @(negedge clk);
        chk("pf ack", 128'(bus.prefetch_ack), 128'(1));
        chk("pf dont", 128'(bus.dont_prefetch), 128'(0));
        if (model_prefetch(16'h2040)) shadow[16'h2040] = {16{8'hC3}};
        @(posedge clk); #1;
        bus.prefetch_valid = 1'b0;
        @(negedge clk);
        chk("pf ack pulse", 128'(bus.prefetch_ack), 128'(0));
        check_req("pf read", 1'b0, 16'h2040, 128'h0, 3, 0, {16{8'hC3}}, 1'b0, 16'h0, 128'h0, 1'b0);

        // Prefetch offered while a miss is in FETCH waits for the next free idle cycle.
        got = 0;
        fork
            model_check("busy read", 1'b0, 16'h3000, 128'h0, 3);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.prefetch_valid = 1'b1; bus.prefetch_address = 16'h4050; bus.prefetch_wdata = {16{8'h5A}};
                @(negedge clk);
                chk("busy dont_prefetch", 128'(bus.dont_prefetch), 128'(1));
                chk("busy no ack", 128'(bus.prefetch_ack), 128'(0));
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (bus.prefetch_ack) begin got = 1; break; end
                end
                chk("busy ack arrives", 128'(got), 128'(1));
                chk("busy ack without req", 128'(bus.mem_read | bus.mem_write), 128'(0));
                if (model_prefetch(16'h4050)) shadow[16'h4050] = {16{8'h5A}};
                @(posedge clk); #1;
                bus.prefetch_valid = 1'b0;
            end
        join
        check_req("busy pf read", 1'b0, 16'h4050, 128'h0, 3, 0, {16{8'h5A}}, 1'b0, 16'h0, 128'h0, 1'b0);

        // CPU hit wins over a simultaneous prefetch offer.
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_address = 16'h2040;
        bus.prefetch_valid = 1'b1; bus.prefetch_address = 16'h5060; bus.prefetch_wdata = {16{8'h77}};
        @(negedge clk);
        chk("sim resp", 128'(bus.mem_resp), 128'(1));
        chk("sim no ack", 128'(bus.prefetch_ack), 128'(0));
        chk("sim rdata", bus.mem_rdata, {16{8'hC3}});
        @(posedge clk); #1;
        bus.mem_read = 1'b0;
        @(negedge clk);
        chk("sim ack after", 128'(bus.prefetch_ack), 128'(1));
        if (model_prefetch(16'h5060)) shadow[16'h5060] = {16{8'h77}};
        @(posedge clk); #1;
        bus.prefetch_valid = 1'b0;
        check_req("sim pf read", 1'b0, 16'h5060, 128'h0, 3, 0, {16{8'h77}}, 1'b0, 16'h0, 128'h0, 1'b0);

        // Reset two cycles into FETCH abandons the miss.
        pm_lat = 20;
        pm_log.delete();
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.mem_address = 16'h6070;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort fetching", 128'(bus.pmem_read), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; bus.mem_read = 1'b0;
        @(negedge clk);
        chk("abort in reset", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort after reset", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
        chk("abort no transfer", 128'(pm_log.size()), 128'(0));
        model_reset();
        shadow = store;
        check_req("abort reread", 1'b0, 16'h6070, 128'h0, 2, 4, init_data(16'h6070), 1'b0, 16'h0, 128'h0, 1'b1);

        // Random traffic over a small address pool against the model.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            a  = (16'($urandom_range(0, 3)) << 7) | (16'($urandom_range(0, 7)) << 4) | 16'($urandom_range(0, 15));
            op = $urandom_range(0, 9);
            L  = $urandom_range(0, 3);
            if (op < 3) begin
                @(posedge clk); #1;
                bus.prefetch_valid = 1'b1; bus.prefetch_address = a; bus.prefetch_wdata = truth(a);
                @(negedge clk);
                chk($sformatf("rnd%0d pf ack", i), 128'(bus.prefetch_ack), 128'(1));
                installed = model_prefetch(a);
                @(posedge clk); #1;
                bus.prefetch_valid = 1'b0;
            end else begin
                d = {$urandom, $urandom, $urandom, $urandom};
                model_check($sformatf("rnd%0d", i), op < 6, a, d, L);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
